// File: rtl/obstacle_detector_nch.sv
// obstacle_detector_nch
//   Multi-channel obstacle detector. Each raw sensor bit is synchronized,
//   debounced, and then drives a per-channel alert level. The level escalates
//   with dwell time while the obstacle stays present.
//
//   state | meaning
//   ------+---------------------------------------------
//   OFF   | no obstacle (filtered value 0)
//   DET   | obstacle just detected, dwell running
//   PERS  | obstacle persisted ESC_CYC cycles, dwell running
//   CRIT  | obstacle persisted 2*ESC_CYC cycles, saturated
//
// Ports
//   clk          block clock, rising edge
//   reset        synchronous active-high reset
//   enable       0 synchronously clears all channel state
//   sensor       raw asynchronous obstacle inputs, one bit per channel
//   mute         per-channel buzzer mask (1 silences that channel's buzz)
//   buzz         per-channel alert level, channel i at [2i+1:2i]
//   detect       per-channel debounced obstacle flag
//   any_detect   OR of detect
//   critical_irq one-cycle pulse, the cycle after any PERS->CRIT step
module obstacle_detector_nch #(
  parameter int N_CH    = 2,
  parameter int DEB_CYC = 4,
  parameter int ESC_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   sensor,
  input  logic [N_CH-1:0]   mute,
  output logic [2*N_CH-1:0] buzz,
  output logic [N_CH-1:0]   detect,
  output logic              any_detect,
  output logic              critical_irq
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int EW = $clog2(ESC_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [EW-1:0] ESC_LAST = EW'(ESC_CYC - 1);
  localparam logic [EW-1:0] ESC_MAX  = EW'(ESC_CYC);

  typedef enum logic [1:0] {
    LVL_OFF  = 2'b00,
    LVL_DET  = 2'b01,
    LVL_PERS = 2'b10,
    LVL_CRIT = 2'b11
  } level_e;

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N_CH-1:0] filt_q, filt_d;
  logic [DW-1:0]   deb_cnt_q [N_CH];
  logic [DW-1:0]   deb_cnt_d [N_CH];
  logic [EW-1:0]   dwell_q [N_CH];
  logic [EW-1:0]   dwell_d [N_CH];
  level_e          level_q [N_CH];
  level_e          level_d [N_CH];
  // esc_q marks the edge a channel entered CRIT; irq follows one edge later.
  logic            esc_q, esc_d;
  logic            irq_q, irq_d;

  always_comb begin
    sync1_d   = sensor;
    sync2_d   = sync1_q;
    filt_d    = filt_q;
    deb_cnt_d = deb_cnt_q;
    dwell_d   = dwell_q;
    level_d   = level_q;
    esc_d     = 1'b0;
    irq_d     = esc_q;

    for (int i = 0; i < N_CH; i++) begin
      // Debounce: count consecutive disagreeing edges, accept on the last one.
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          filt_d[i]    = ~filt_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end else begin
        deb_cnt_d[i] = '0;
      end

      // Level FSM advances on the same edge the filtered value changes.
      if (filt_d[i] && !filt_q[i]) begin
        level_d[i] = LVL_DET;
        dwell_d[i] = '0;
      end else if (!filt_d[i] && filt_q[i]) begin
        level_d[i] = LVL_OFF;
        dwell_d[i] = '0;
      end else if (filt_q[i]) begin
        unique case (level_q[i])
          LVL_DET: begin
            if (dwell_q[i] == ESC_LAST) begin
              level_d[i] = LVL_PERS;
              dwell_d[i] = '0;
            end else begin
              dwell_d[i] = dwell_q[i] + EW'(1);
            end
          end
          LVL_PERS: begin
            if (dwell_q[i] == ESC_LAST) begin
              level_d[i] = LVL_CRIT;
              dwell_d[i] = ESC_MAX;
              esc_d      = 1'b1;
            end else begin
              dwell_d[i] = dwell_q[i] + EW'(1);
            end
          end
          LVL_CRIT: dwell_d[i] = dwell_q[i];
          default:  level_d[i] = LVL_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      esc_q   <= 1'b0;
      irq_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= '0;
        dwell_q[i]   <= '0;
        level_q[i]   <= LVL_OFF;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      esc_q   <= esc_d;
      irq_q   <= irq_d;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        dwell_q[i]   <= dwell_d[i];
        level_q[i]   <= level_d[i];
      end
    end
  end

  always_comb begin
    buzz = '0;
    for (int i = 0; i < N_CH; i++) begin
      buzz[2*i +: 2] = level_q[i] & {2{~mute[i]}};
    end
  end

  assign detect       = filt_q;
  assign any_detect   = |filt_q;
  assign critical_irq = irq_q;

endmodule

// File: tb/tb_obstacle_detector_nch.sv
// Scoreboard bench for obstacle_detector_nch (N_CH=2, DEB_CYC=4, ESC_CYC=8).
// Stimulus pushes hand-computed expected outputs tagged with the edge count
// after which they must hold; the monitor compares them on the falling edge.
module tb_obstacle_detector_nch;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] sensor;
  logic [1:0] mute;
  logic [3:0] buzz;
  logic [1:0] detect;
  logic       any_detect;
  logic       critical_irq;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int         exp_cyc_q[$];
  logic [6:0] exp_val_q[$];
  string      exp_name_q[$];

  obstacle_detector_nch #(.N_CH(2), .DEB_CYC(4), .ESC_CYC(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sensor       (sensor),
    .mute         (mute),
    .buzz         (buzz),
    .detect       (detect),
    .any_detect   (any_detect),
    .critical_irq (critical_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int at, input logic [3:0] bz, input logic [1:0] det,
                      input logic irq, input string name);
    exp_cyc_q.push_back(at);
    exp_val_q.push_back({bz, det, irq});
    exp_name_q.push_back(name);
  endtask

  // Monitor: compare every expectation that is due in this cycle.
  always @(negedge clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      int         at;
      logic [6:0] ev;
      string      nm;
      logic [7:0] act, req;
      at = exp_cyc_q.pop_front();
      ev = exp_val_q.pop_front();
      nm = exp_name_q.pop_front();
      n_checks++;
      act = {buzz, detect, any_detect, critical_irq};
      req = {ev[6:1], |ev[2:1], ev[0]};
      if (at != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for edge %0d seen at edge %0d", nm, at, cyc);
      end else if (act !== req) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got buzz=%b detect=%b any=%b irq=%b, want buzz=%b detect=%b any=%b irq=%b",
                 nm, cyc, act[7:4], act[3:2], act[1], act[0],
                 req[7:4], req[3:2], req[1], req[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int base;
    reset  = 1'b1;
    enable = 1'b1;
    sensor = 2'b11;
    mute   = 2'b00;

    // Reset held two edges with obstacles present, then both channels
    // escalate together to CRIT.
    push(1, 4'b0000, 2'b00, 1'b0, "reset_e1");
    push(2, 4'b0000, 2'b00, 1'b0, "reset_e2");
    wait_cyc(2);
    reset = 1'b0;
    base = cyc;
    push(base + 5,  4'b0000, 2'b00, 1'b0, "deb_before");
    push(base + 6,  4'b0101, 2'b11, 1'b0, "det_both");
    push(base + 13, 4'b0101, 2'b11, 1'b0, "det_hold");
    push(base + 14, 4'b1010, 2'b11, 1'b0, "pers_both");
    push(base + 21, 4'b1010, 2'b11, 1'b0, "pers_hold");
    push(base + 22, 4'b1111, 2'b11, 1'b0, "crit_both");
    push(base + 23, 4'b1111, 2'b11, 1'b1, "irq_single");
    push(base + 24, 4'b1111, 2'b11, 1'b0, "irq_drop");

    // Release channel 0 from CRIT, then re-assert it.
    wait_cyc(28);
    sensor = 2'b10;
    base = cyc;
    push(base + 5, 4'b1111, 2'b11, 1'b0, "rel_before");
    push(base + 6, 4'b1100, 2'b10, 1'b0, "rel_off");
    wait_cyc(36);
    sensor = 2'b11;
    base = cyc;
    push(base + 6,  4'b1101, 2'b11, 1'b0, "redet");
    push(base + 13, 4'b1101, 2'b11, 1'b0, "redet_hold");
    push(base + 14, 4'b1110, 2'b11, 1'b0, "redet_pers");

    // Drop enable while channel 0 is in PERS.
    wait_cyc(base + 16);
    enable = 1'b0;
    push(cyc + 1, 4'b0000, 2'b00, 1'b0, "enable_clr");

    // Channel 1 alone; mute it in PERS and through CRIT.
    wait_cyc(cyc + 1);
    enable = 1'b1;
    sensor = 2'b10;
    base = cyc;
    push(base + 5,  4'b0000, 2'b00, 1'b0, "ch1_before");
    push(base + 6,  4'b0100, 2'b10, 1'b0, "ch1_det");
    push(base + 14, 4'b1000, 2'b10, 1'b0, "ch1_pers");
    wait_cyc(base + 15);
    mute = 2'b10;
    push(base + 15, 4'b0000, 2'b10, 1'b0, "mute_pers");
    push(base + 22, 4'b0000, 2'b10, 1'b0, "mute_crit");
    push(base + 23, 4'b0000, 2'b10, 1'b1, "mute_irq");
    wait_cyc(base + 24);
    mute = 2'b00;
    push(base + 24, 4'b1100, 2'b10, 1'b0, "unmute_crit");

    // Reset from CRIT, then a 3-cycle glitch on channel 0.
    wait_cyc(base + 25);
    reset = 1'b1;
    push(cyc + 1, 4'b0000, 2'b00, 1'b0, "reset_crit");
    wait_cyc(cyc + 1);
    reset  = 1'b0;
    sensor = 2'b01;
    base = cyc;
    for (int k = 3; k <= 10; k++) push(base + k, 4'b0000, 2'b00, 1'b0, "glitch");
    wait_cyc(base + 3);
    sensor = 2'b00;

    wait_cyc(base + 12);
    for (int k = 0; k < 20 && exp_cyc_q.size() > 0; k++) @(posedge clk);
    if (exp_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_cyc_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
